// File: rtl/cphy_lane_seq_ctrl.sv
// Master-side C-PHY lane sequencer: LP line states for HS entry/exit and bus turnaround,
// with ownership of the TX timer enable/seed. Every output is registered.
module cphy_lane_seq_ctrl #(
  parameter int unsigned TRAIL_CYCLES = 20
) (
  input  logic       clk,
  input  logic       RstN,
  input  logic       HsReq,
  input  logic       TaReq,
  input  logic       BusReturn,
  input  logic       Timeout,
  output logic       TimerEn,
  output logic       TimerSeed,
  output logic [2:0] LpLevel,
  output logic       LpOe,
  output logic       HsEn,
  output logic       HsReady,
  output logic       TaDone,
  output logic       Busy,
  output logic [3:0] dbg_state
);

  typedef enum logic [3:0] {
    STOP      = 4'd0,
    HS_RQST   = 4'd1,
    HS_PREP   = 4'd2,
    HS_ACTIVE = 4'd3,
    HS_TRAIL  = 4'd4,
    TA_RQST   = 4'd5,
    TA_YIELD  = 4'd6,
    TA_GO     = 4'd7,
    RX_OWN    = 4'd8
  } state_t;

  localparam logic [7:0] TRAIL_LAST = 8'(TRAIL_CYCLES);

  state_t     state, state_nx;
  logic [1:0] rst_sync;
  logic       rst_n;
  logic [7:0] trail_cnt;
  logic       timeout_ok;
  logic       timed_nx;

  // Reset asserts asynchronously everywhere, releases two clk edges later.
  always_ff @(posedge clk or negedge RstN) begin
    if (!RstN) rst_sync <= 2'b00;
    else       rst_sync <= {rst_sync[0], 1'b1};
  end
  assign rst_n = rst_sync[1];

  // TimerEn is low on the first cycle of every timed state, so only a
  // Timeout from the freshly restarted timer can move the sequence on.
  assign timeout_ok = Timeout & TimerEn;

  always_comb begin
    state_nx = state;
    case (state)
      STOP: begin
        if (HsReq)      state_nx = HS_RQST;
        else if (TaReq) state_nx = TA_RQST;
      end
      HS_RQST: begin
        if (!HsReq)          state_nx = STOP;
        else if (timeout_ok) state_nx = HS_PREP;
      end
      HS_PREP: begin
        if (!HsReq)          state_nx = STOP;
        else if (timeout_ok) state_nx = HS_ACTIVE;
      end
      HS_ACTIVE: if (!HsReq) state_nx = HS_TRAIL;
      HS_TRAIL:  if (trail_cnt == TRAIL_LAST) state_nx = STOP;
      TA_RQST:   if (timeout_ok) state_nx = TA_YIELD;
      TA_YIELD:  if (timeout_ok) state_nx = TA_GO;
      TA_GO:     if (timeout_ok) state_nx = RX_OWN;
      RX_OWN:    if (BusReturn) state_nx = STOP;
      default:   state_nx = STOP;
    endcase
  end

  always_comb begin
    timed_nx = 1'b0;
    case (state_nx)
      HS_RQST, HS_PREP, TA_RQST, TA_YIELD, TA_GO: timed_nx = 1'b1;
      default: timed_nx = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= STOP;
      trail_cnt <= 8'd0;
    end else begin
      state <= state_nx;
      if (state_nx == HS_TRAIL)
        trail_cnt <= (state == HS_TRAIL) ? trail_cnt + 8'd1 : 8'd1;
      else
        trail_cnt <= 8'd0;
    end
  end

  // Outputs are decoded from the next state so they line up with the state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      LpLevel   <= 3'b111;
      LpOe      <= 1'b1;
      HsEn      <= 1'b0;
      HsReady   <= 1'b0;
      TimerEn   <= 1'b0;
      TimerSeed <= 1'b0;
      TaDone    <= 1'b0;
      Busy      <= 1'b0;
    end else begin
      case (state_nx)
        HS_RQST, TA_RQST:                     LpLevel <= 3'b001;
        HS_PREP, HS_ACTIVE, HS_TRAIL,
        TA_YIELD, TA_GO:                      LpLevel <= 3'b000;
        default:                              LpLevel <= 3'b111;
      endcase
      LpOe      <= (state_nx != RX_OWN);
      HsEn      <= (state_nx == HS_ACTIVE) || (state_nx == HS_TRAIL);
      HsReady   <= (state_nx == HS_ACTIVE);
      TimerSeed <= (state_nx == TA_GO);
      TimerEn   <= timed_nx && (state_nx == state);
      TaDone    <= (state_nx == RX_OWN) && (state != RX_OWN);
      Busy      <= (state_nx != STOP);
    end
  end

  assign dbg_state = state;

endmodule
